alu_arbiter: RTL and testbench

Shares one 64-bit ALU between two requesters (e.g. execute stage and address-generation unit) using round-robin arbitration and valid/ready handshakes. Each accepted operation is registered, executed on the shared ALU, and returned with its N/Z/V/C flags and originating requester ID. An architectural flag register updates for operations that request it.

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_alu.sv | 55 +++++
 rtl/alu_arbiter_rr_arb2.sv | 36 +++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Covers op encodings, FSM states and flag bit positions.
package alu_arbiter_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// 64-bit combinational ALU producing a result and {N,Z,V,C} flags.
// Reserved encodings yield a zero result.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      cntrl,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;
    logic          ovf;
    logic          carry;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        carry  = 1'b0;
        case (cntrl)
            OP_PASS_B: result = b;
            OP_ADD: begin
                result = sum[XLEN-1:0];
                carry  = sum[XLEN];
                ovf    = (a[XLEN-1] == b[XLEN-1]) &&
                         (result[XLEN-1] != a[XLEN-1]);
            end
            // Carry out of a subtract is the inverted borrow.
            OP_SUB: begin
                result = diff[XLEN-1:0];
                carry  = ~diff[XLEN];
                ovf    = (a[XLEN-1] != b[XLEN-1]) &&
                         (result[XLEN-1] != a[XLEN-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[XLEN-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_V] = ovf;
        flags[FLAG_C] = carry;
    end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the last grant moves only on accept.
// Reset favours requester 0 on the first contention.
module alu_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 64-bit ALU between two requesters with round-robin
// arbitration, registered operands, responses and a flag register.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [2:0]      req0_cntrl,
    input  logic            req0_setflags,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [2:0]      req1_cntrl,
    input  logic            req1_setflags,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic [3:0]      rsp_flags,
    output logic [3:0]      flags_q
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [2:0]      op_cntrl_q, op_cntrl_d;
    logic            op_setflags_q, op_setflags_d;
    logic            op_id_q, op_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_id_q, rsp_id_d;
    logic [3:0]      flags_d;

    logic [1:0]      grant;
    logic            accept;
    logic            sel;
    logic [XLEN-1:0] alu_result;
    logic [3:0]      alu_flags;

    alu_arbiter_rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant)
    );

    alu_arbiter_alu u_alu (
        .a      (op_a_q),
        .b      (op_b_q),
        .cntrl  (op_cntrl_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Held low while reset is asserted so nothing is offered pre-reset.
    assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel       = grant[1];

    always_comb begin
        state_d       = state_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_cntrl_d    = op_cntrl_q;
        op_setflags_d = op_setflags_q;
        op_id_d       = op_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_id_d      = rsp_id_q;
        flags_d       = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_a_d        = sel ? req1_a : req0_a;
                    op_b_d        = sel ? req1_b : req0_b;
                    op_cntrl_d    = sel ? req1_cntrl : req0_cntrl;
                    op_setflags_d = sel ? req1_setflags : req0_setflags;
                    op_id_d       = sel;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                rsp_id_d     = op_id_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (op_setflags_q) begin
                        flags_d = rsp_flags_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_cntrl_q    <= '0;
            op_setflags_q <= 1'b0;
            op_id_q       <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_id_q      <= 1'b0;
            flags_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_cntrl_q    <= op_cntrl_d;
            op_setflags_q <= op_setflags_d;
            op_id_q       <= op_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_id_q      <= rsp_id_d;
            flags_q       <= flags_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] a_m [2];
    logic [63:0] b_m [2];
    logic [2:0]  c_m [2];
    logic        sf_m [2];
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags_q;

    logic [1:0]  v;
    int          last_m;
    logic [3:0]  flags_m;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req0_a        (a_m[0]),
        .req0_b        (b_m[0]),
        .req0_cntrl    (c_m[0]),
        .req0_setflags (sf_m[0]),
        .req1_a        (a_m[1]),
        .req1_b        (b_m[1]),
        .req1_cntrl    (c_m[1]),
        .req1_setflags (sf_m[1]),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .flags_q       (flags_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: flags from plain signed/unsigned arithmetic on the operands.
    task automatic ref_alu(input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] c, output logic [63:0] r,
                           output logic [3:0] f);
        logic signed [65:0] sa, sb, sr;
        logic signed [65:0] smax, smin;
        logic [64:0]        usum;
        logic               vv, cc;
        sa   = 66'($signed(a));
        sb   = 66'($signed(b));
        smax = 66'sd9223372036854775807;
        smin = -smax - 66'sd1;
        usum = 65'(a) + 65'(b);
        vv   = 1'b0;
        cc   = 1'b0;
        r    = 64'd0;
        case (c)
            3'b000: r = b;
            3'b010: begin
                r  = a + b;
                sr = sa + sb;
                vv = (sr > smax) || (sr < smin);
                cc = usum[64];
            end
            3'b011: begin
                r  = a - b;
                sr = sa - sb;
                vv = (sr > smax) || (sr < smin);
                cc = (a >= b);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = 64'd0;
        endcase
        f = {r[63], r == 64'd0, vv, cc};
    endtask

    task automatic set_req(input int i, input logic [63:0] a,
                           input logic [63:0] b, input logic [2:0] c,
                           input logic s);
        a_m[i]  = a;
        b_m[i]  = b;
        c_m[i]  = c;
        sf_m[i] = s;
        v[i]    = 1'b1;
        req_valid = v;
    endtask

    // One full transaction from IDLE; hold = cycles of response stall.
    task automatic step(input int hold);
        int          g;
        logic [63:0] er;
        logic [3:0]  ef;
        #1;
        if (v == 2'b11) g = (last_m == 1) ? 0 : 1;
        else            g = v[0] ? 0 : 1;
        chk("grant", 64'(req_ready), (g == 0) ? 64'd1 : 64'd2);
        ref_alu(a_m[g], b_m[g], c_m[g], er, ef);
        @(posedge clk);
        @(negedge clk);
        v[g] = 1'b0;
        req_valid = v;
        last_m = g;
        chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("exec_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_result", rsp_result, er);
        chk("rsp_flags", 64'(rsp_flags), 64'(ef));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_result", rsp_result, er);
            chk("hold_ready", 64'(req_ready), 64'd0);
            chk("hold_flags_q", 64'(flags_q), 64'(flags_m));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (sf_m[g]) flags_m = ef;
        chk("flags_q", 64'(flags_q), 64'(flags_m));
        chk("done_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        v         = 2'b00;
        req_valid = 2'b00;
        last_m    = 1;
        flags_m   = 4'd0;
        for (int i = 0; i < 2; i++) begin
            a_m[i] = '0; b_m[i] = '0; c_m[i] = '0; sf_m[i] = 1'b0;
        end

        // Contention from reset: req0 ADD 1+1, req1 SUB 3-3
        set_req(0, 64'd1, 64'd1, 3'b010, 1'b0);
        set_req(1, 64'd3, 64'd3, 3'b011, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_flags_q", 64'(flags_q), 64'd0);
        reset_n = 1'b1;
        step(0);
        step(0);
        set_req(0, 64'd10, 64'd20, 3'b101, 1'b0);
        set_req(1, 64'd10, 64'd20, 3'b100, 1'b0);
        step(0);
        step(0);

        // Single op with setflags
        set_req(0, 64'd5, 64'd7, 3'b010, 1'b1);
        step(0);
        chk("single_flags_q", 64'(flags_q), 64'd0);

        // Signed overflow
        set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1);
        step(0);
        chk("ovf_flags_q", 64'(flags_q), 64'hA);

        // setflags=0 leaves flag register alone
        set_req(0, 64'd0, 64'd1, 3'b011, 1'b0);
        step(0);
        chk("nosf_flags_q", 64'(flags_q), 64'hA);

        // Back-pressure, then reserved encodings
        set_req(1, 64'h1234, 64'h00FF, 3'b110, 1'b1);
        step(5);
        set_req(0, 64'hDEAD, 64'hBEEF, 3'b001, 1'b1);
        step(1);
        chk("rsvd_flags_q", 64'(flags_q), 64'h4);
        set_req(1, 64'hDEAD, 64'hBEEF, 3'b111, 1'b0);
        step(0);

        // Randomized traffic; held requests keep their payload
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && ($urandom_range(0, 1) == 1)) begin
                    logic [63:0] ra, rb;
                    ra = {$urandom, $urandom};
                    rb = ($urandom_range(0, 3) == 0) ? ra
                                                     : {$urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) ra[63] = rb[63];
                    set_req(i, ra, rb, 3'($urandom_range(0, 7)),
                            1'($urandom_range(0, 1)));
                end
            end
            if (v == 2'b00) begin
                set_req(int'($urandom_range(0, 1)), {$urandom, $urandom},
                        {$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'b1);
            end
            step(int'($urandom_range(0, 2)));
        end
        while (v != 2'b00) step(0);

        // Reset during EXEC discards the op and clears state
        set_req(1, 64'd9, 64'd9, 3'b011, 1'b1);
        #1;
        @(posedge clk);
        @(negedge clk);
        v = 2'b00;
        req_valid = v;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_flags_q", 64'(flags_q), 64'd0);
        set_req(0, 64'd2, 64'd3, 3'b010, 1'b1);
        set_req(1, 64'd4, 64'd6, 3'b011, 1'b1);
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        last_m  = 1;
        flags_m = 4'd0;
        step(0);
        step(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
